// File: rtl/mbi5124_pkg.sv
// Shared types and helpers for the MBI5124 link receive monitor.
package mbi5124_pkg;

    localparam int unsigned DW_DEFAULT = 16;
    localparam int unsigned CW_DEFAULT = 5;
    localparam logic [DW_DEFAULT-1:0] LEDS_ALL_OFF = '1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFTING,
        OVERRUN
    } state_t;

    typedef struct packed {
        logic                  valid;
        logic [CW_DEFAULT-1:0] pos;
    } dec_t;

    // All ones -> 0, single zero at k -> k+1, anything else -> invalid with pos 0.
    function automatic dec_t one_cold_to_pos(input logic [DW_DEFAULT-1:0] word);
        dec_t        res;
        int unsigned zeros;
        res   = '0;
        zeros = 0;
        for (int unsigned i = 0; i < DW_DEFAULT; i++) begin
            if (!word[i]) begin
                zeros   = zeros + 1;
                res.pos = CW_DEFAULT'(i + 1);
            end
        end
        res.valid = (zeros <= 1);
        if (!res.valid) begin
            res.pos = '0;
        end
        return res;
    endfunction

endpackage

// File: rtl/mbi_sync_edge.sv
// N-stage input synchronizer with a rising-edge strobe on the synchronized output.
module mbi_sync_edge #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_d,
    output logic o_q,
    output logic o_rise
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync <= {STAGES{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_q    = r_sync[STAGES-1];
    assign o_rise = r_sync[STAGES-1] & ~r_prev;

endmodule

// File: rtl/mbi5124_rx_monitor.sv
// Rebuilds the MBI5124 shift register/latch from the sampled link and checks frames.
// Optional FRAME_STATS_EN adds frame_cnt / err_cnt statistics outputs.
module mbi5124_rx_monitor
    import mbi5124_pkg::*;
#(
    parameter int unsigned DW          = DW_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CW          = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          sdi,
    input  logic          led_clk,
    input  logic          le,
    input  logic          oe,
    input  logic          err_clr,
    output logic [DW-1:0] leds_out,
    output logic [DW-1:0] latched,
    output logic [CW-1:0] value_out,
    output logic          frame_valid,
    output logic          frame_err,
    output logic          pattern_err
`ifdef FRAME_STATS_EN
    ,
    output logic [15:0]   frame_cnt,
    output logic [15:0]   err_cnt
`endif
);

    localparam int unsigned     CNT_W   = 6;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic w_sdi_s, w_sdi_rise, w_clk_s, w_clk_rise, w_le_s, w_le_rise, w_oe_s, w_oe_rise;
    logic w_unused;

    mbi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
        .clk(clk), .rstn(rstn), .i_d(sdi), .o_q(w_sdi_s), .o_rise(w_sdi_rise));
    mbi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_clk (
        .clk(clk), .rstn(rstn), .i_d(led_clk), .o_q(w_clk_s), .o_rise(w_clk_rise));
    mbi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_le (
        .clk(clk), .rstn(rstn), .i_d(le), .o_q(w_le_s), .o_rise(w_le_rise));
    mbi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_oe (
        .clk(clk), .rstn(rstn), .i_d(oe), .o_q(w_oe_s), .o_rise(w_oe_rise));

    assign w_unused = ^{w_sdi_rise, w_clk_s, w_le_s, w_oe_rise};

    logic [DW-1:0]    r_shift, r_latched, r_leds;
    logic [CW-1:0]    r_value;
    logic [CNT_W-1:0] r_cnt;
    logic             r_fv, r_ferr, r_perr, r_lat_pend, r_short_pend;
    state_t           r_state, w_state_next;

    // A shift coincident with a latch is applied first, so the latch sees the post-shift word.
    logic [DW-1:0]    w_shift_next;
    logic [CNT_W-1:0] w_cnt_next;
    dec_t             w_dec;
    logic             w_ferr_set, w_perr_set;

    assign w_shift_next = w_clk_rise ? {w_sdi_s, r_shift[DW-1:1]} : r_shift;
    assign w_cnt_next   = (w_clk_rise && r_cnt != CNT_MAX) ? r_cnt + CNT_W'(1) : r_cnt;
    assign w_dec        = one_cold_to_pos(DW_DEFAULT'(r_latched));
    assign w_ferr_set   = r_lat_pend & r_short_pend;
    assign w_perr_set   = r_lat_pend & ~w_dec.valid;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_le_rise) begin
            w_state_next = IDLE;
        end else if (w_clk_rise) begin
            case (r_state)
                IDLE:     w_state_next = SHIFTING;
                SHIFTING: if (w_cnt_next == CNT_W'(DW + 1)) w_state_next = OVERRUN;
                default:  w_state_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_shift      <= LEDS_ALL_OFF;
            r_latched    <= LEDS_ALL_OFF;
            r_leds       <= LEDS_ALL_OFF;
            r_value      <= '0;
            r_cnt        <= '0;
            r_fv         <= 1'b0;
            r_ferr       <= 1'b0;
            r_perr       <= 1'b0;
            r_lat_pend   <= 1'b0;
            r_short_pend <= 1'b0;
        end else begin
            r_shift <= w_shift_next;
            if (w_le_rise) begin
                r_latched    <= w_shift_next;
                r_cnt        <= '0;
                r_lat_pend   <= 1'b1;
                r_short_pend <= (w_cnt_next != CNT_W'(DW));
            end else begin
                r_cnt      <= w_cnt_next;
                r_lat_pend <= 1'b0;
            end
            // Decode stage: flags and value land together with frame_valid.
            r_fv <= r_lat_pend;
            if (r_lat_pend) begin
                r_value <= CW'(w_dec.pos);
            end
            r_ferr <= w_ferr_set | (r_ferr & ~err_clr);
            r_perr <= w_perr_set | (r_perr & ~err_clr);
            r_leds <= w_oe_s ? LEDS_ALL_OFF : r_latched;
        end
    end

`ifdef FRAME_STATS_EN
    logic [15:0] r_frame_cnt, r_err_cnt;
    logic        w_err_inc;

    assign w_err_inc = w_ferr_set | w_perr_set;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
        end else begin
            if (r_lat_pend) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            if (err_clr) begin
                r_err_cnt <= w_err_inc ? 16'd1 : 16'd0;
            end else if (w_err_inc && r_err_cnt != 16'hFFFF) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    assign frame_cnt = r_frame_cnt;
    assign err_cnt   = r_err_cnt;
`endif

    assign leds_out    = r_leds;
    assign latched     = r_latched;
    assign value_out   = r_value;
    assign frame_valid = r_fv;
    assign frame_err   = r_ferr;
    assign pattern_err = r_perr;

endmodule
